// File: rtl/ro_freq_meter.sv
// ro_freq_meter: counts rising edges of a divided ring-oscillator signal over a programmable gate window
// Ports: clk, rst_n (async active-low); ro_in (async oscillator input); start + gate_sel (window
//        W = 2^(gate_sel+MIN_LOG2) cycles); busy while measuring; done pulses when result/overflow update.
module ro_freq_meter #(
   parameter int CNT_W    = 16,
   parameter int MIN_LOG2 = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ro_in,
   input  logic             start,
   input  logic [2:0]       gate_sel,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] result,
   output logic             overflow
);
   // one extra bit so the longest window 2^(7+MIN_LOG2) fits in the gate counter
   localparam int GW = MIN_LOG2 + 8;
   typedef enum logic {IDLE, MEASURE} state_t;
   state_t           state;
   logic             s1, s2, s3, rise, sat, ovf_flag, next_ovf;
   logic [CNT_W-1:0] edge_cnt, next_cnt;
   logic [GW-1:0]    gate_cnt;
   always_comb begin
      rise     = s2 & ~s3;
      sat      = &edge_cnt;
      next_cnt = (rise && !sat) ? edge_cnt + 1'b1 : edge_cnt;
      next_ovf = ovf_flag | (rise & sat);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {s3, s2, s1} <= '0;
         state        <= IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         result       <= '0;
         overflow     <= 1'b0;
         edge_cnt     <= '0;
         ovf_flag     <= 1'b0;
         gate_cnt     <= '0;
      end else begin
         {s3, s2, s1} <= {s2, s1, ro_in};
         done         <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
               state    <= MEASURE;
               busy     <= 1'b1;
               edge_cnt <= '0;
               ovf_flag <= 1'b0;
               // the gate counter holds the window length, so gate_sel is not needed afterwards
               gate_cnt <= GW'(1) << (gate_sel + MIN_LOG2);
            end
         end else begin
            gate_cnt <= gate_cnt - 1'b1;
            edge_cnt <= next_cnt;
            ovf_flag <= next_ovf;
            // last window cycle: publish the count including a rise seen in this cycle
            if (gate_cnt == GW'(1)) begin
               state    <= IDLE;
               busy     <= 1'b0;
               done     <= 1'b1;
               result   <= next_cnt;
               overflow <= next_ovf;
            end
         end
      end
   end
endmodule

// File: tb/tb_ro_freq_meter.sv
// tb_ro_freq_meter: scoreboard bench for ro_freq_meter (16-bit and 8-bit counter instances)
module tb_ro_freq_meter;
   localparam int N = 16384;
   typedef struct {int dc; int cnt;} ev_t;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ro_in = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  gate_sel = 3'd0;
   logic        busy16, done16, ovf16, busy8, done8, ovf8;
   logic [15:0] res16;
   logic [7:0]  res8;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   bit          pro[N];
   bit          pst[N];
   logic [2:0]  pgs[N];
   bit          exp_busy[N];
   ev_t         ev[$];
   int          rp[2] = '{0, 0};
   int          r_exp[2] = '{0, 0};
   int          o_exp[2] = '{0, 0};
   int          busy_end = -1;

   ro_freq_meter dut16 (.clk(clk), .rst_n(rst_n), .ro_in(ro_in), .start(start), .gate_sel(gate_sel),
                        .busy(busy16), .done(done16), .result(res16), .overflow(ovf16));
   ro_freq_meter #(.CNT_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .ro_in(ro_in), .start(start), .gate_sel(gate_sel),
                        .busy(busy8), .done(done8), .result(res8), .overflow(ovf8));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int expv);
      checks++;
      if (act != expv) begin
         failures++;
         if (failures <= 20) $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   // monitor: a done is expected exactly in the cycle recorded by the model for the next event
   task automatic mon(input int i, input logic b, input logic d, input logic [15:0] r, input logic o);
      int  mx;
      ev_t e;
      mx = (i == 0) ? 65535 : 255;
      chk($sformatf("busy%0d", i), int'(b), int'(exp_busy[cyc]));
      if (rp[i] < ev.size() && ev[rp[i]].dc == cyc) begin
         e = ev[rp[i]];
         rp[i]++;
         chk($sformatf("done%0d", i), int'(d), 1);
         r_exp[i] = (e.cnt > mx) ? mx : e.cnt;
         o_exp[i] = (e.cnt > mx) ? 1 : 0;
      end else
         chk($sformatf("done_idle%0d", i), int'(d), 0);
      chk($sformatf("result%0d", i), int'(r), r_exp[i]);
      chk($sformatf("overflow%0d", i), int'(o), o_exp[i]);
   endtask

   always @(negedge clk) begin
      mon(0, busy16, done16, res16, ovf16);
      mon(1, busy8, done8, {8'd0, res8}, ovf8);
   end

   // reference: a start driven after edge n is accepted unless a window is open; the window covers
   // edges k+1..k+W (k=n+1); an ro_in rise driven after edge m reaches the counter 3 edges later
   task automatic model(input int from, input int to);
      int k, w, cnt;
      for (int n = from; n <= to; n++) begin
         if (pst[n] && n + 1 > busy_end) begin
            k = n + 1;
            w = 16 << pgs[n];
            cnt = 0;
            for (int m = k - 2; m <= k + w - 3; m++) if (pro[m] && !pro[m-1]) cnt++;
            ev.push_back('{k + w, cnt});
            for (int c = k; c < k + w; c++) exp_busy[c] = 1'b1;
            busy_end = k + w;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic play(input int n);
      for (int i = 0; i < n; i++) begin
         ro_in = pro[cyc];
         start = pst[cyc];
         gate_sel = pgs[cyc];
         tick();
      end
   endtask

   task automatic run(input int len);
      model(cyc, cyc + len - 1);
      play(len);
   endtask

   task automatic fill_per(input int a, input int len, input int p, input int ph);
      for (int i = 0; i < len; i++) pro[a+i] = ((i + ph) % p) < (p / 2);
   endtask

   task automatic fill_rand(input int a, input int len);
      bit lvl;
      int i, r;
      lvl = pro[a-1];
      i = a;
      while (i < a + len) begin
         r = $urandom_range(1, 4);
         lvl = ~lvl;
         for (int j = 0; j < r && i < a + len; j++) begin
            pro[i] = lvl;
            i++;
         end
      end
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_busy16"}, int'(busy16), 0);
      chk({nm, "_done16"}, int'(done16), 0);
      chk({nm, "_res16"}, int'(res16), 0);
      chk({nm, "_ovf16"}, int'(ovf16), 0);
      chk({nm, "_busy8"}, int'(busy8), 0);
      chk({nm, "_done8"}, int'(done8), 0);
      chk({nm, "_res8"}, int'(res8), 0);
      chk({nm, "_ovf8"}, int'(ovf8), 0);
   endtask

   initial begin
      int from, s, gs, w, gap, len;
      for (int n = 0; n < N; n++) pgs[n] = 3'($urandom_range(0, 7));
      tick();
      tick();
      chk_zero("reset");
      rst_n = 1'b1;
      play(6);
      // periodic count, period 4, W=16
      from = cyc;
      fill_per(from, 30, 4, 0);
      pst[from+3] = 1'b1;
      pgs[from+3] = 3'd0;
      run(30);
      // longest window, period 8, W=2048
      from = cyc;
      fill_per(from, 2060, 8, 0);
      pst[from+3] = 1'b1;
      pgs[from+3] = 3'd7;
      run(2060);
      // saturation with period 2, W=512, then a run with ro_in held low
      from = cyc;
      fill_per(from, 530, 2, 0);
      pst[from+3] = 1'b1;
      pgs[from+3] = 3'd5;
      run(530);
      from = cyc;
      pst[from+3] = 1'b1;
      pgs[from+3] = 3'd5;
      run(530);
      // ignored start mid-run, then a start in the done cycle
      from = cyc;
      fill_rand(from, 80);
      pst[from+3] = 1'b1;
      pgs[from+3] = 3'd1;
      pst[from+15] = 1'b1;
      pst[from+36] = 1'b1;
      pgs[from+36] = 3'd1;
      run(80);
      // reset at the 8th cycle of a W=16 window
      from = cyc;
      fill_per(from, 10, 4, 0);
      pst[from+2] = 1'b1;
      pgs[from+2] = 3'd0;
      model(from, from + 40);
      play(10);
      rst_n = 1'b0;
      #1;
      chk_zero("abort");
      void'(ev.pop_back());
      for (int c = cyc; c < cyc + 40; c++) exp_busy[c] = 1'b0;
      r_exp = '{0, 0};
      o_exp = '{0, 0};
      busy_end = -1;
      play(3);
      rst_n = 1'b1;
      play(10);
      // ro_in toggling while idle
      from = cyc;
      fill_per(from, 100, 6, 1);
      run(100);
      // randomized runs with optional ignored and chained starts
      for (int r = 0; r < 20; r++) begin
         gs = $urandom_range(0, 3);
         w = 16 << gs;
         gap = $urandom_range(1, 6);
         len = gap + 2 * (w + 1) + 10;
         from = cyc;
         fill_rand(from, len);
         s = from + gap;
         pst[s] = 1'b1;
         pgs[s] = 3'(gs);
         if ($urandom_range(0, 1) == 1) pst[s+1+w/2] = 1'b1;
         if ($urandom_range(0, 1) == 1) begin
            pst[s+1+w] = 1'b1;
            pgs[s+1+w] = 3'(gs);
         end
         run(len);
      end
      play(20);
      chk("drain16", rp[0], ev.size());
      chk("drain8", rp[1], ev.size());
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ro_freq_meter.md
# ro_freq_meter

Measurement back-end for the ring-oscillator tiles. It counts rising edges of an (already divided) oscillator output over a programmable gate window of `clk` cycles and holds the result for readout. The oscillator tile sits on one end, and the tile's pin-mux or scan readout logic sits on the other. One measurement runs per `start` pulse; the result stays stable until the next measurement completes.

## Interface
- `CNT_W`, default 16: width of the edge counter and the result.
- `MIN_LOG2`, default 4: log2 of the shortest gate window.
- `clk` in 1: system clock. All logic runs on its rising edge.
- `rst_n` in 1: reset. Asynchronous, active-low; one clock domain.
- `ro_in` in 1: oscillator signal, asynchronous to `clk`. Its frequency must be below f_clk/2 (pre-divided).
- `start` in 1: single-cycle request to begin a measurement.
- `gate_sel` in 3: window length W = 2^(gate_sel + MIN_LOG2) cycles. Sampled when `start` is accepted.
- `busy` out 1: high while a measurement is in progress.
- `done` out 1: one-cycle pulse when `result` is updated.
- `result` out CNT_W: edge count of the last completed measurement.
- `overflow` out 1: the last measurement saturated.

## Operation
- Input path:
  - `ro_in` passes through a 2-FF synchronizer (s1, s2), then a third flop s3.
  - rise = s2 & ~s3.
  - All three flops reset to 0.
- States:
  - IDLE: `busy`=0.
  - MEASURE: `busy`=1.
- Leaving IDLE:
  - IDLE with `start`=1 → MEASURE.
  - On that transition: edge counter cleared to 0, overflow flag cleared, gate counter loaded with W, `gate_sel` latched.
- In MEASURE, every cycle:
  - The gate counter decrements.
  - If rise=1, the edge counter increments. If it is already at 2^CNT_W−1, it holds that value and sets the internal overflow flag.
- MEASURE with gate counter = 1 → IDLE.
  - On that edge, `result` takes the final count, including a rise in this last cycle.
  - `overflow` takes the flag.
  - `done` is driven high for exactly the next cycle.
- Exactly W MEASURE cycles are sampled. A rise is counted only in cycles where state = MEASURE.
- `start` while `busy`=1 is ignored. There is no queueing and no restart.
- `gate_sel` changes during MEASURE have no effect.
- `result` and `overflow` change only on measurement completion or reset.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, `overflow`=0. Edge counter, gate counter and synchronizer flops are all 0.
- Reset asserted mid-measurement aborts it immediately:
  - No `done` pulse.
  - `result` and `overflow` go to 0.
- `start` sampled high at edge k:
  - `busy`=1 from after edge k through edge k+W.
  - `done`=1 for the cycle after edge k+W, with `busy`=0 in that cycle.
- A `start` in the same cycle as `done`=1 is accepted. Back-to-back measurements therefore have a period of W+1 cycles.
- `ro_in` to rise latency: 2–3 cycles.
  - Edges up to 3 cycles before the window opens may be counted.
  - Edges within the final 2 cycles of the window are not counted.
  - The error is at most ±1 count.
- If `ro_in` is high at reset release, one spurious rise occurs 2 cycles later. It is counted only if MEASURE is already active.

## Test plan
- Periodic count: reset, then `ro_in` with period 4 clk (2 high/2 low). `gate_sel`=0, `start` pulse. Expect:
  - `busy` high for 16 cycles.
  - `done` pulse.
  - `result`=4 (±1), `overflow`=0.
- Longest window: `gate_sel`=7 (W=2048), `ro_in` period 8 clk. Expect `result`=256 (±1) and `done` exactly 2049 cycles after the start edge.
- Saturation: CNT_W=8, `gate_sel`=5 (W=512), `ro_in` period 2 clk. Expect `result`=255 and `overflow`=1. A following run with `ro_in` held low gives `result`=0 and `overflow`=0.
- Ignored start, then chained run:
  - Pulse `start` mid-measurement: `busy` timing is unchanged and only one `done` occurs.
  - `start` in the `done` cycle: a new measurement begins with `busy` high the next cycle.
- Reset mid-run: assert `rst_n`=0 at cycle 8 of a W=16 measurement. Expect all outputs 0 immediately, with no `done` after release until a new `start`.
- Hold: `ro_in` toggling while IDLE for 100 cycles. Expect `result` unchanged and `done` never asserted.
